mem_copy_dma: RTL and testbench
===============================

# mem_copy_dma

Block-copy engine that is the initiator side of the tiny16 word-memory port. It sequences the memory's address-latch, write-enable and read-data signals to copy `len` 16-bit words from `src` to `dst` without CPU involvement. It sits between the control logic, which supplies start/src/dst/len, and the memory block, which it drives through the same MAR-latch / write / combinational-read interface the CPU uses.

## Interface
Parameters:
- `MEM_SIZE`, default 256: number of words in the attached memory. Used for range checking.

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: request a copy. Sampled only in IDLE.
- `src` input 16: first source word address. Sampled with `start`.
- `dst` input 16: first destination word address. Sampled with `start`.
- `len` input 16: word count. Sampled with `start`.
- `abort` input 1: stop the transfer at the next edge.
- `busy` output 1: high from the cycle after accepted `start` until DONE exits.
- `done` output 1: one-cycle pulse at end of every accepted request.
- `err` output 1: range error on the last request. Held until the next accepted `start`.
- `count` output 16: words written so far in the current or last request.
- `mem_addr_en` output 1: load the memory MAR from `mem_addr`.
- `mem_addr` output 16: address to latch.
- `mem_in_en` output 1: write `mem_in` to `mem[MAR]` at the edge.
- `mem_in` output 16: write data.
- `mem_out_en` output 1: read strobe. High in RD; informational.
- `mem_out` input 16: combinational `mem[MAR]`.

## Operation
- States: IDLE, RA (read address), RD (read data / write address), WR (write), DONE.
- **IDLE:**
  - `start`=1: latch src/dst/len into internal registers; clear `count` and `err`.
  - Range check, done in 17 bits: if `src+len > MEM_SIZE` or `dst+len > MEM_SIZE`, set `err`=1 and go to DONE.
  - Else if `len`=0, go to DONE.
  - Else go to RA.
- **RA:** `mem_addr_en`=1, `mem_addr`=src_reg+count. Go to RD.
- **RD:**
  - Capture `mem_out` into the data register at the edge. MAR now holds the source address.
  - `mem_addr_en`=1, `mem_addr`=dst_reg+count, `mem_out_en`=1. Go to WR.
- **WR:**
  - `mem_in_en`=1, `mem_in`=data register. The write lands at the edge.
  - `count` increments at the same edge.
  - If the new `count` equals len_reg, go to DONE; else go to RA.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- Address arithmetic is 16-bit. The range check guarantees no wrap for legal requests.
- Copy direction is forward, ascending addresses, one word at a time.
  - Overlap with dst>src and dst<src+len propagates the first words: a defined, non-memmove result.
- **abort** (sampled at an edge in RA/RD/WR):
  - RA/RD: go to DONE. The pending word is not written.
  - WR: the write in that cycle still commits and `count` increments, then go to DONE.
  - `abort` in IDLE/DONE: ignored.
- `start` while `busy` or in DONE: ignored. Inputs are not re-sampled.
- Outside RA/RD/WR, the `mem_*` enables are 0 and `mem_addr`/`mem_in` are 0.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - State=IDLE; busy=0, done=0, err=0, count=0.
  - All `mem_*` outputs and internal registers 0.
  - Reset mid-transfer abandons it immediately. Words already written stay written.
- Enable outputs are Moore, decoded from state, glitch-free at edges.
- Let edge E0 accept `start`. Cycle k means the cycle after E0+k-1:
  - Word i (0-based) is in RA in cycle 3i+1, RD in 3i+2, WR in 3i+3.
  - DONE (`done`=1) is in cycle 3·len+1.
  - `busy`=1 from cycle 1 through cycle 3·len+1 inclusive.
- `len`=0 or range error: DONE in cycle 1, no memory enables asserted.
- `count` reaches len at the edge ending the final WR and holds until the next accepted `start`.
- A new `start` is accepted at the earliest on the edge ending the first IDLE cycle after DONE.
- Throughput: 3 cycles per word.

## Test plan
- **Basic copy:** mem[0x10..0x12]=0xAAAA,0xBBBB,0xCCCC; start src=0x10, dst=0x40, len=3 → mem[0x40..0x42] match, done in cycle 10, count=3, err=0, source unchanged.
- **Zero length:** len=0 → done in cycle 1; no `mem_addr_en`/`mem_in_en` pulses; count=0.
- **Range error:** MEM_SIZE=256, src=0xF0, len=0x20 → err=1, done in cycle 1, no memory access. A following legal start clears err.
- **Abort:**
  - abort asserted during word 1 RD of a len=4 copy → words 0 only written, count=1, done next cycle, dst+1..3 untouched.
  - abort in word 1 WR → count=2.
- **Start while busy plus async reset:**
  - Second start mid-copy is ignored; the first completes unchanged.
  - `rst` low mid-copy → all outputs 0 immediately; IDLE after release; earlier written words intact.
- **Overlap forward:** mem[0..3]=1,2,3,4; src=0, dst=1, len=3 → mem[0..3]=1,1,1,1.

Source files
------------

// File: rtl/mem_copy_dma_if.sv
// rtl/mem_copy_dma_if.sv - tiny16 word-memory port: MAR latch, write strobe, combinational read
//
// Signals:
//   mem_addr_en  initiator -> memory  load MAR from mem_addr at the edge
//   mem_addr     initiator -> memory  address to latch (16 bits)
//   mem_in_en    initiator -> memory  write mem_in to mem[MAR] at the edge
//   mem_in       initiator -> memory  write data (16 bits)
//   mem_out_en   initiator -> memory  read strobe, informational only
//   mem_out      memory -> initiator  combinational mem[MAR] (16 bits)
// Modports: master = initiator (DMA / CPU), slave = memory.
interface mem_copy_dma_if;
    logic        mem_addr_en;
    logic [15:0] mem_addr;
    logic        mem_in_en;
    logic [15:0] mem_in;
    logic        mem_out_en;
    logic [15:0] mem_out;

    modport master (
        output mem_addr_en,
        output mem_addr,
        output mem_in_en,
        output mem_in,
        output mem_out_en,
        input  mem_out
    );

    modport slave (
        input  mem_addr_en,
        input  mem_addr,
        input  mem_in_en,
        input  mem_in,
        input  mem_out_en,
        output mem_out
    );
endinterface

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - block-copy engine driving the tiny16 word-memory port
//
// Parameters:
//   MEM_SIZE  words in the attached memory, bound for the range check
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   start            copy request, sampled only in IDLE together with src/dst/len
//   src, dst, len    first source address, first destination address, word count
//   abort            end the transfer at the next edge (RA/RD/WR only)
//   busy             high from the cycle after an accepted start until DONE exits
//   done             one-cycle pulse at the end of every accepted request
//   err              range error on the last request, held until the next start
//   count            words written in the current or last request
//   mem              memory port (master side), see mem_copy_dma_if
module mem_copy_dma #(
    parameter int MEM_SIZE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] count,
    mem_copy_dma_if.master mem
);

    typedef enum logic [2:0] {
        IDLE,
        RA,
        RD,
        WR,
        DONE
    } state_t;

    localparam logic [16:0] LIMIT = 17'(MEM_SIZE);

    state_t      state;
    logic [15:0] src_reg;
    logic [15:0] dst_reg;
    logic [15:0] len_reg;

    // Registered memory-port outputs; each is loaded on the edge entering
    // the state that owns it, so the port is a clean Moore decode.
    logic        addr_en_q;
    logic [15:0] addr_q;
    logic        in_en_q;
    logic [15:0] in_q;      // doubles as the data register captured in RD
    logic        out_en_q;

    logic [16:0] src_end;
    logic [16:0] dst_end;
    logic        range_bad;
    logic [15:0] count_next;

    // 17-bit sums so an end address of exactly 0x10000 is still caught.
    assign src_end    = {1'b0, src} + {1'b0, len};
    assign dst_end    = {1'b0, dst} + {1'b0, len};
    assign range_bad  = (src_end > LIMIT) || (dst_end > LIMIT);
    assign count_next = count + 16'd1;

    assign mem.mem_addr_en = addr_en_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_in_en   = in_en_q;
    assign mem.mem_in      = in_q;
    assign mem.mem_out_en  = out_en_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
            addr_en_q <= 1'b0;
            addr_q    <= '0;
            in_en_q   <= 1'b0;
            in_q      <= '0;
            out_en_q  <= 1'b0;
        end else begin
            // Port outputs and done fall back to 0 unless the next state sets them.
            addr_en_q <= 1'b0;
            addr_q    <= '0;
            in_en_q   <= 1'b0;
            in_q      <= '0;
            out_en_q  <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        src_reg <= src;
                        dst_reg <= dst;
                        len_reg <= len;
                        count   <= '0;
                        err     <= range_bad;
                        busy    <= 1'b1;
                        if (range_bad || (len == 16'd0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RA;
                            addr_en_q <= 1'b1;
                            addr_q    <= src;
                        end
                    end
                end

                RA: begin
                    if (abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RD;
                        addr_en_q <= 1'b1;
                        addr_q    <= dst_reg + count;
                        out_en_q  <= 1'b1;
                    end
                end

                RD: begin
                    // mem_out still reflects the source address here; the MAR
                    // only moves to the destination at this edge.
                    if (abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= WR;
                        in_en_q <= 1'b1;
                        in_q    <= mem.mem_out;
                    end
                end

                WR: begin
                    // The write in this cycle always commits, abort or not.
                    count <= count_next;
                    if (abort || (count_next == len_reg)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RA;
                        addr_en_q <= 1'b1;
                        addr_q    <= src_reg + count_next;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - directed table-driven bench for mem_copy_dma with a 256-word memory model
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [15:0] len = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] count;

    mem_copy_dma_if bus ();

    mem_copy_dma #(.MEM_SIZE(256)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .count (count),
        .mem   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: MAR latch, write at edge into mem[MAR], combinational read.
    logic [15:0] mem [0:255];
    logic [15:0] mar = '0;
    logic        ld_all = 1'b0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    function automatic logic [15:0] pat(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {lo ^ 8'h3C, ~lo};
    endfunction

    always @(posedge clk) begin
        if (ld_all) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(16'(i));
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else begin
            if (bus.mem_addr_en) mar <= bus.mem_addr;
            if (bus.mem_in_en) mem[mar[7:0]] <= bus.mem_in;
        end
    end
    assign bus.mem_out = mem[mar[7:0]];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill();
        @(negedge clk);
        ld_all = 1'b1;
        @(negedge clk);
        ld_all = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        int          abort_cyc;   // cycle during which abort is held (0 = none)
        int          poke_cyc;    // cycle carrying a stray start (0 = none)
        int          exp_cyc;     // cycle in which done must be high
        int          exp_cnt;
        int          exp_addr;    // mem_addr_en cycles expected
        bit          exp_err;
    } vec_t;

    vec_t vt [13];

    // Applies one request and checks done timing, busy, port activity and final status.
    task automatic run(input vec_t v);
        int  k;
        bit  seen;
        bit  busy_ok;
        int  writes;
        int  addrs;
        @(negedge clk);
        start = 1'b1;
        src = v.src;
        dst = v.dst;
        len = v.len;
        @(posedge clk);
        #1;
        start = 1'b0;
        src = 16'hDEAD;
        dst = 16'hBEEF;
        len = 16'h0007;
        k = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        writes = 0;
        addrs = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            abort = (k == v.abort_cyc);
            if (k == v.poke_cyc) begin
                start = 1'b1;
                src = 16'h0020;
                dst = 16'h0060;
                len = 16'h0005;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (bus.mem_in_en === 1'b1) writes++;
            if (bus.mem_addr_en === 1'b1) addrs++;
            if (done === 1'b1) seen = 1'b1;
        end
        abort = 1'b0;
        start = 1'b0;
        check("done_cycle", k, v.exp_cyc);
        check("busy_while_active", {31'd0, busy_ok}, 1);
        check("write_strobes", writes, v.exp_cnt);
        check("addr_strobes", addrs, v.exp_addr);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 0);
        check("count", {16'd0, count}, v.exp_cnt);
        check("err", {31'd0, err}, {31'd0, v.exp_err});
    endtask

    // Whole-memory image: copied window holds source pattern, everything else untouched.
    task automatic check_image(input vec_t v);
        int bad;
        int first;
        logic [15:0] e;
        bad = 0;
        first = -1;
        for (int a = 0; a < 256; a++) begin
            e = pat(16'(a));
            if (!v.exp_err && a >= int'(v.dst) && a < int'(v.dst) + v.exp_cnt)
                e = pat(v.src + 16'(a - int'(v.dst)));
            if (mem[a] !== e) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        check($sformatf("mem_image bad_words(first=%0d)", first), bad, 0);
    endtask

    vec_t hv;

    initial begin
        //          src      dst      len      ab  pk  cyc cnt adr err
        vt[0]  = '{16'h10, 16'h40, 16'h03,  0,  0, 10, 3,  6, 1'b0};
        vt[1]  = '{16'h05, 16'h06, 16'h00,  0,  0,  1, 0,  0, 1'b0};
        vt[2]  = '{16'hF0, 16'h00, 16'h20,  0,  0,  1, 0,  0, 1'b1};
        vt[3]  = '{16'h20, 16'h50, 16'h02,  0,  0,  7, 2,  4, 1'b0};
        vt[4]  = '{16'h00, 16'hFF, 16'h02,  0,  0,  1, 0,  0, 1'b1};
        vt[5]  = '{16'hFE, 16'h00, 16'h02,  0,  0,  7, 2,  4, 1'b0};
        vt[6]  = '{16'h30, 16'hFF, 16'h01,  0,  0,  4, 1,  2, 1'b0};
        vt[7]  = '{16'hFFFF, 16'h00, 16'h01, 0, 0,  1, 0,  0, 1'b1};
        vt[8]  = '{16'h00, 16'h00, 16'hFFFF, 0, 0,  1, 0,  0, 1'b1};
        vt[9]  = '{16'h60, 16'h80, 16'h04,  4,  0,  5, 1,  3, 1'b0};
        vt[10] = '{16'h60, 16'h80, 16'h04,  5,  0,  6, 1,  4, 1'b0};
        vt[11] = '{16'h60, 16'h80, 16'h04,  6,  0,  7, 2,  4, 1'b0};
        vt[12] = '{16'h10, 16'h40, 16'h03,  0,  4, 10, 3,  6, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_status", {busy, done, err, count}, 0);
        check("reset_port", {bus.mem_addr_en, bus.mem_in_en, bus.mem_out_en, bus.mem_addr, bus.mem_in}, 0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            fill();
            run(vt[i]);
            check_image(vt[i]);
        end

        // Basic copy with specific data; source must be unchanged.
        fill();
        poke(8'h10, 16'hAAAA);
        poke(8'h11, 16'hBBBB);
        poke(8'h12, 16'hCCCC);
        run(vt[0]);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] d;
            d = (i == 0) ? 16'hAAAA : (i == 1) ? 16'hBBBB : 16'hCCCC;
            check($sformatf("basic_dst[%0d]", i), mem[8'h40 + i], d);
            check($sformatf("basic_src[%0d]", i), mem[8'h10 + i], d);
        end

        // Forward overlap propagates the first word.
        for (int i = 0; i < 4; i++) poke(8'(i), 16'(i + 1));
        hv = '{16'h00, 16'h01, 16'h03, 0, 0, 10, 3, 6, 1'b0};
        run(hv);
        for (int i = 0; i < 4; i++)
            check($sformatf("overlap[%0d]", i), mem[i], 16'h0001);

        // Asynchronous reset mid-copy: word 0 already written, word 1 not.
        fill();
        @(negedge clk);
        start = 1'b1;
        src = 16'h10;
        dst = 16'h50;
        len = 16'h04;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_status", {busy, done, err, count}, 0);
        check("async_reset_port", {bus.mem_addr_en, bus.mem_in_en, bus.mem_out_en, bus.mem_addr, bus.mem_in}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, done, count}, 0);
        check("reset_word0_kept", mem[8'h50], pat(16'h10));
        check("reset_word1_untouched", mem[8'h51], pat(16'h51));
        run(vt[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
